cart_mem_bridge: RTL and testbench

- Sits directly downstream of the cartridge mapper and converts its level-style ROM/SRAM strobes into single transactions on the shared SDRAM port.
- Returns read data to the mapper and holds it stable while the strobe stays asserted.
- Drives a wait signal so the bus master stalls until data is valid.
- Tracks SRAM dirtiness for the save-file logic.

---
 rtl/cart_mem_pkg.sv | 43 ++++
 rtl/cart_mem_edge.sv | 49 ++++
 rtl/cart_mem_bridge.sv | 187 ++++++++++++++++++
 tb/tb_cart_mem_bridge.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_mem_pkg.sv
// Shared types and constants for the cartridge-to-SDRAM bridge.
// Access kinds are encoded in arbitration order, highest priority first.
package cart_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        K_ROMW  = 2'd0,
        K_SRAMW = 2'd1,
        K_ROMR  = 2'd2,
        K_SRAMR = 2'd3
    } kind_e;

    localparam int N_KINDS = 4;

    // Slot 0 (LSBs) holds the highest-priority kind.
    localparam logic [2*N_KINDS-1:0] PRIO_ORDER = {K_SRAMR, K_ROMR, K_SRAMW, K_ROMW};

    localparam logic [24:0] DEF_SRAM_BASE = 25'h1F00000;
    localparam logic [24:0] DEF_ROM_BASE  = 25'h0000000;

    typedef struct packed {
        logic rom_rd;
        logic rom_wrl;
        logic rom_wrh;
        logic sram_rd;
        logic sram_wr;
    } strobes_t;

    function automatic kind_e pick_kind(input logic [N_KINDS-1:0] req);
        kind_e k;
        k = kind_e'(PRIO_ORDER[2*(N_KINDS-1) +: 2]);
        for (int i = N_KINDS - 1; i >= 0; i--) begin
            if (req[PRIO_ORDER[2*i +: 2]]) k = kind_e'(PRIO_ORDER[2*i +: 2]);
        end
        return k;
    endfunction

endpackage

// File: rtl/cart_mem_edge.sv
// Turns level strobes from the mapper into one-cycle new-access pulses,
// one per access kind: a strobe rising, or the address moving under a held strobe.
module cart_mem_edge
    import cart_mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  strobes_t           strb,
    input  logic [22:0]        rom_a,
    input  logic [14:0]        sram_a,
    output logic [N_KINDS-1:0] new_acc
);

    strobes_t    strb_d, strb_q;
    logic [22:0] rom_a_d, rom_a_q;
    logic [14:0] sram_a_d, sram_a_q;
    logic        rom_a_chg, sram_a_chg, rom_wr_held;

    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    always_comb begin
        strb_d      = strb;
        rom_a_d     = rom_a;
        sram_a_d    = sram_a;
        rom_a_chg   = (rom_a != rom_a_q);
        sram_a_chg  = (sram_a != sram_a_q);
        rom_wr_held = (strb.rom_wrl | strb.rom_wrh) & (strb_q.rom_wrl | strb_q.rom_wrh);

        new_acc          = '0;
        new_acc[K_ROMW]  = (strb.rom_wrl & ~strb_q.rom_wrl) | (strb.rom_wrh & ~strb_q.rom_wrh)
                         | (rom_wr_held & rom_a_chg);
        new_acc[K_SRAMW] = strb.sram_wr & (~strb_q.sram_wr | sram_a_chg);
        new_acc[K_ROMR]  = strb.rom_rd  & (~strb_q.rom_rd  | rom_a_chg);
        new_acc[K_SRAMR] = strb.sram_rd & (~strb_q.sram_rd | sram_a_chg);
    end

    // NOTE: state flops use non-blocking assignment so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strb_q   <= '0;
            rom_a_q  <= '0;
            sram_a_q <= '0;
        end else begin
            strb_q   <= strb_d;
            rom_a_q  <= rom_a_d;
            sram_a_q <= sram_a_d;
        end
    end

endmodule

// File: rtl/cart_mem_bridge.sv
// Bridges the mapper's ROM/SRAM strobes onto a single request/ack SDRAM port,
// with a one-entry ROM read cache and an SRAM dirty flag for save handling.
module cart_mem_bridge
    import cart_mem_pkg::*;
#(
    parameter logic [24:0] SRAM_BASE = DEF_SRAM_BASE,
    parameter logic [24:0] ROM_BASE  = DEF_ROM_BASE
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [22:0] ROM_A,
    input  logic [15:0] ROM_DO,
    input  logic        ROM_RD,
    input  logic        ROM_WRL,
    input  logic        ROM_WRH,
    output logic [15:0] ROM_DI,
    input  logic [14:0] SRAM_A,
    input  logic [7:0]  SRAM_DO,
    input  logic        SRAM_RD,
    input  logic        SRAM_WR,
    output logic [7:0]  SRAM_DI,
    output logic        WAIT_N,
    output logic        SRAM_DIRTY,
    input  logic        SRAM_CLR,
    output logic [24:0] MEM_ADDR,
    output logic [15:0] MEM_DO,
    output logic [1:0]  MEM_BE,
    output logic        MEM_WE,
    output logic        MEM_REQ,
    input  logic        MEM_ACK,
    input  logic [15:0] MEM_DI
);

    strobes_t           strb;
    logic [N_KINDS-1:0] new_acc, cand;
    kind_e              sel;
    logic [24:0]        rom_addr, sram_addr;
    logic               rom_hit;

    state_e             state_d, state_q;
    kind_e              kind_d, kind_q;
    logic [N_KINDS-1:0] pend_d, pend_q;
    logic               mem_req_d, mem_req_q, mem_we_d, mem_we_q;
    logic [1:0]         mem_be_d, mem_be_q;
    logic [24:0]        mem_addr_d, mem_addr_q;
    logic [15:0]        mem_do_d, mem_do_q, rom_di_d, rom_di_q;
    logic [7:0]         sram_di_d, sram_di_q;
    logic               wait_n_d, wait_n_q, dirty_d, dirty_q;
    logic [22:0]        tag_d, tag_q;
    logic               tag_vld_d, tag_vld_q;

    assign strb = {ROM_RD, ROM_WRL, ROM_WRH, SRAM_RD, SRAM_WR};

    cart_mem_edge u_edge (
        .clk     (CLK),
        .rst_n   (RST_N),
        .strb    (strb),
        .rom_a   (ROM_A),
        .sram_a  (SRAM_A),
        .new_acc (new_acc)
    );

    // Address sums wrap modulo 2^25; bit 0 is forced low since the port is word-wide.
    assign rom_addr  = (ROM_BASE  + {1'b0, ROM_A, 1'b0})  & ~25'd1;
    assign sram_addr = (SRAM_BASE + {9'd0, SRAM_A, 1'b0}) & ~25'd1;
    assign rom_hit   = tag_vld_q && (ROM_A == tag_q);
    assign cand      = new_acc | pend_q;
    assign sel       = pick_kind(cand);

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        pend_d     = pend_q | new_acc;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_be_d   = mem_be_q;
        mem_addr_d = mem_addr_q;
        mem_do_d   = mem_do_q;
        rom_di_d   = rom_di_q;
        sram_di_d  = sram_di_q;
        wait_n_d   = wait_n_q;
        dirty_d    = SRAM_CLR ? 1'b0 : dirty_q;
        tag_d      = tag_q;
        tag_vld_d  = tag_vld_q;

        case (state_q)
            IDLE: begin
                if (|cand) begin
                    pend_d = cand & ~(4'b0001 << sel);
                    // A cache hit is served from ROM_DI as-is; nothing goes to SDRAM.
                    if (!(sel == K_ROMR && rom_hit)) begin
                        state_d   = BUSY;
                        kind_d    = sel;
                        mem_req_d = 1'b1;
                        wait_n_d  = 1'b0;
                        case (sel)
                            K_ROMW: begin
                                mem_addr_d = rom_addr;
                                mem_be_d   = {ROM_WRH, ROM_WRL};
                                mem_we_d   = 1'b1;
                                mem_do_d   = ROM_DO;
                                if (ROM_A == tag_q) tag_vld_d = 1'b0;
                            end
                            K_SRAMW: begin
                                mem_addr_d = sram_addr;
                                mem_be_d   = 2'b01;
                                mem_we_d   = 1'b1;
                                mem_do_d   = {8'h00, SRAM_DO};
                                dirty_d    = 1'b1;
                            end
                            K_ROMR: begin
                                mem_addr_d = rom_addr;
                                mem_be_d   = 2'b11;
                                mem_we_d   = 1'b0;
                                tag_d      = ROM_A;
                                tag_vld_d  = 1'b0;
                            end
                            default: begin
                                mem_addr_d = sram_addr;
                                mem_be_d   = 2'b01;
                                mem_we_d   = 1'b0;
                            end
                        endcase
                    end
                end
            end
            BUSY: begin
                if (MEM_ACK) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    wait_n_d  = 1'b1;
                    if (kind_q == K_ROMR) begin
                        rom_di_d  = MEM_DI;
                        tag_vld_d = 1'b1;
                    end
                    if (kind_q == K_SRAMR) sram_di_d = MEM_DI[7:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            kind_q     <= K_ROMW;
            pend_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= 2'b00;
            mem_addr_q <= '0;
            mem_do_q   <= '0;
            rom_di_q   <= 16'hFFFF;
            sram_di_q  <= 8'hFF;
            wait_n_q   <= 1'b1;
            dirty_q    <= 1'b0;
            tag_q      <= '0;
            tag_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            pend_q     <= pend_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_be_q   <= mem_be_d;
            mem_addr_q <= mem_addr_d;
            mem_do_q   <= mem_do_d;
            rom_di_q   <= rom_di_d;
            sram_di_q  <= sram_di_d;
            wait_n_q   <= wait_n_d;
            dirty_q    <= dirty_d;
            tag_q      <= tag_d;
            tag_vld_q  <= tag_vld_d;
        end
    end

    assign MEM_REQ    = mem_req_q;
    assign MEM_WE     = mem_we_q;
    assign MEM_BE     = mem_be_q;
    assign MEM_ADDR   = mem_addr_q;
    assign MEM_DO     = mem_do_q;
    assign ROM_DI     = rom_di_q;
    assign SRAM_DI    = sram_di_q;
    assign WAIT_N     = wait_n_q;
    assign SRAM_DIRTY = dirty_q;

endmodule

// File: tb/tb_cart_mem_bridge.sv
// Self-checking bench for cart_mem_bridge: a transaction-level model predicts
// the SDRAM requests, read data, wait cycles and dirty flag for each access batch.
module tb_cart_mem_bridge;

    localparam logic [24:0] ROM_BASE_TB  = 25'h0000000;
    localparam logic [24:0] SRAM_BASE_TB = 25'h1F00000;
    localparam int T_ROMW = 0, T_SRAMW = 1, T_ROMR = 2, T_SRAMR = 3;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [22:0] ROM_A;
    logic [15:0] ROM_DO;
    logic        ROM_RD, ROM_WRL, ROM_WRH;
    logic [15:0] ROM_DI;
    logic [14:0] SRAM_A;
    logic [7:0]  SRAM_DO;
    logic        SRAM_RD, SRAM_WR;
    logic [7:0]  SRAM_DI;
    logic        WAIT_N, SRAM_DIRTY, SRAM_CLR;
    logic [24:0] MEM_ADDR;
    logic [15:0] MEM_DO;
    logic [1:0]  MEM_BE;
    logic        MEM_WE, MEM_REQ, MEM_ACK;
    logic [15:0] MEM_DI;

    cart_mem_bridge dut (
        .CLK(CLK), .RST_N(RST_N),
        .ROM_A(ROM_A), .ROM_DO(ROM_DO), .ROM_RD(ROM_RD), .ROM_WRL(ROM_WRL), .ROM_WRH(ROM_WRH),
        .ROM_DI(ROM_DI),
        .SRAM_A(SRAM_A), .SRAM_DO(SRAM_DO), .SRAM_RD(SRAM_RD), .SRAM_WR(SRAM_WR), .SRAM_DI(SRAM_DI),
        .WAIT_N(WAIT_N), .SRAM_DIRTY(SRAM_DIRTY), .SRAM_CLR(SRAM_CLR),
        .MEM_ADDR(MEM_ADDR), .MEM_DO(MEM_DO), .MEM_BE(MEM_BE), .MEM_WE(MEM_WE),
        .MEM_REQ(MEM_REQ), .MEM_ACK(MEM_ACK), .MEM_DI(MEM_DI)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [24:0] addr;
        logic [1:0]  be;
        logic        we;
        logic [15:0] dout;
        int          kind;
    } txn_t;

    txn_t        expq[$];
    txn_t        cur;
    bit          have_cur;
    int          n_vec, n_err, n_req, wait_low, req_age, ack_delay;
    bit          auto_ack, fix_en;
    logic [15:0] fix_data;

    // Reference state: what the mapper should see, and the one-entry cache contents.
    logic [15:0] exp_rom_di;
    logic [7:0]  exp_sram_di;
    logic        exp_dirty;
    logic [22:0] m_tag;
    bit          m_vld;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample on the falling edge and play the SDRAM side.
    task automatic cycle();
        @(negedge CLK);
        MEM_ACK = 1'b0;
        if (!WAIT_N) wait_low++;
        if (MEM_REQ && auto_ack) begin
            if (req_age == 0) begin
                n_req++;
                if (expq.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                    have_cur = 1'b0;
                end else begin
                    cur      = expq.pop_front();
                    have_cur = 1'b1;
                    check("mem_addr", 32'(MEM_ADDR), 32'(cur.addr));
                    check("mem_be",   32'(MEM_BE),   32'(cur.be));
                    check("mem_we",   32'(MEM_WE),   32'(cur.we));
                    if (cur.we) check("mem_do", 32'(MEM_DO), 32'(cur.dout));
                end
            end else if (have_cur) begin
                check("hold_addr", 32'(MEM_ADDR), 32'(cur.addr));
                check("hold_be",   32'(MEM_BE),   32'(cur.be));
            end
            if (req_age == ack_delay) begin
                MEM_ACK = 1'b1;
                MEM_DI  = fix_en ? fix_data : 16'($urandom);
                if (have_cur && cur.kind == T_ROMR) begin
                    exp_rom_di = MEM_DI;
                    m_vld      = 1'b1;
                end
                if (have_cur && cur.kind == T_SRAMR) exp_sram_di = MEM_DI[7:0];
                req_age = 0;
            end else begin
                req_age++;
            end
        end else begin
            req_age = 0;
        end
    endtask

    task automatic push(input logic [24:0] addr, input logic [1:0] be, input logic we,
                        input logic [15:0] dout, input int kind);
        txn_t t;
        t.addr = addr; t.be = be; t.we = we; t.dout = dout; t.kind = kind;
        expq.push_back(t);
    endtask

    // Serve a batch of simultaneous accesses in priority order against the current inputs.
    task automatic plan(input logic [1:0] rom_wr, input bit sramw, input bit romr, input bit sramr);
        logic [24:0] ra, sa;
        ra = 25'(32'(ROM_A) * 2 + 32'(ROM_BASE_TB));
        sa = 25'(32'(SRAM_A) * 2 + 32'(SRAM_BASE_TB));
        if (rom_wr != 2'b00) begin
            push(ra, rom_wr, 1'b1, ROM_DO, T_ROMW);
            if (m_vld && m_tag == ROM_A) m_vld = 1'b0;
        end
        if (sramw) begin
            push(sa, 2'b01, 1'b1, {8'h00, SRAM_DO}, T_SRAMW);
            exp_dirty = 1'b1;
        end
        if (romr && !(m_vld && m_tag == ROM_A)) begin
            push(ra, 2'b11, 1'b0, 16'h0000, T_ROMR);
            m_tag = ROM_A;
            m_vld = 1'b0;
        end
        if (sramr) push(sa, 2'b01, 1'b0, 16'h0000, T_SRAMR);
    endtask

    task automatic access(input logic [1:0] rom_wr, input bit sramw, input bit romr, input bit sramr,
                          input int dly, input bit clr, input bit hold,
                          output int wlow, output int nreq);
        int  pushed, req0;
        bit  done;
        ack_delay = dly;
        if (clr) exp_dirty = 1'b0;
        plan(rom_wr, sramw, romr, sramr);
        pushed   = expq.size();
        req0     = n_req;
        wait_low = 0;
        ROM_WRL  = rom_wr[0];
        ROM_WRH  = rom_wr[1];
        SRAM_WR  = sramw;
        ROM_RD   = romr;
        SRAM_RD  = sramr;
        SRAM_CLR = clr;
        done     = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            cycle();
            SRAM_CLR = 1'b0;
            if (expq.size() == 0 && !MEM_REQ) done = 1'b1;
        end
        if (!done) begin
            check("timeout", 32'd0, 32'd1);
            expq.delete();
        end
        if (!hold) begin
            ROM_WRL = 1'b0; ROM_WRH = 1'b0; SRAM_WR = 1'b0; ROM_RD = 1'b0; SRAM_RD = 1'b0;
        end
        cycle();
        cycle();
        wlow = wait_low;
        nreq = n_req - req0;
        check("wait_cycles", 32'(wlow), 32'(pushed * (dly + 1)));
        check("req_count",   32'(nreq), 32'(pushed));
        check("rom_di",      32'(ROM_DI), 32'(exp_rom_di));
        check("sram_di",     32'(SRAM_DI), 32'(exp_sram_di));
        check("sram_dirty",  32'(SRAM_DIRTY), 32'(exp_dirty));
    endtask

    int wl, nr;

    initial begin
        RST_N = 1'b0; ROM_A = '0; ROM_DO = '0; ROM_RD = 0; ROM_WRL = 0; ROM_WRH = 0;
        SRAM_A = '0; SRAM_DO = '0; SRAM_RD = 0; SRAM_WR = 0; SRAM_CLR = 0;
        MEM_ACK = 0; MEM_DI = '0;
        auto_ack = 1'b1; fix_en = 1'b0; fix_data = '0; have_cur = 1'b0;
        exp_rom_di = 16'hFFFF; exp_sram_di = 8'hFF; exp_dirty = 1'b0; m_tag = '0; m_vld = 1'b0;

        repeat (3) cycle();
        check("rst_mem_req",  32'(MEM_REQ), 32'd0);
        check("rst_mem_we",   32'(MEM_WE), 32'd0);
        check("rst_mem_be",   32'(MEM_BE), 32'd0);
        check("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        check("rst_mem_do",   32'(MEM_DO), 32'd0);
        check("rst_rom_di",   32'(ROM_DI), 32'hFFFF);
        check("rst_sram_di",  32'(SRAM_DI), 32'hFF);
        check("rst_wait_n",   32'(WAIT_N), 32'd1);
        check("rst_dirty",    32'(SRAM_DIRTY), 32'd0);
        RST_N = 1'b1;
        cycle();

        // ROM read miss with a 4-cycle-late ack.
        ROM_A = 23'h000100; fix_en = 1'b1; fix_data = 16'hBEEF;
        access(2'b00, 0, 1, 0, 4, 0, 0, wl, nr);
        fix_en = 1'b0;
        check("t1_rom_di",   32'(ROM_DI), 32'hBEEF);
        check("t1_wait_low", 32'(wl), 32'd5);

        // Same address again hits the cache.
        access(2'b00, 0, 1, 0, 2, 0, 0, wl, nr);
        check("t2_hit_no_req", 32'(nr), 32'd0);
        check("t2_hit_rom_di", 32'(ROM_DI), 32'hBEEF);

        // ROM low-byte write to the tag address invalidates the cache.
        ROM_DO = 16'hA5C3;
        access(2'b01, 0, 0, 0, 1, 0, 0, wl, nr);
        access(2'b00, 0, 1, 0, 0, 0, 0, wl, nr);
        check("t3_miss_after_wr", 32'(nr), 32'd1);

        // SRAM write at the top of the window; then CLR alone, then CLR racing a write.
        SRAM_A = 15'h7FFF; SRAM_DO = 8'h5A;
        access(2'b00, 1, 0, 0, 0, 0, 0, wl, nr);
        check("t4_dirty_set", 32'(SRAM_DIRTY), 32'd1);
        SRAM_CLR = 1'b1; cycle(); SRAM_CLR = 1'b0; cycle();
        exp_dirty = 1'b0;
        check("t4_dirty_clr", 32'(SRAM_DIRTY), 32'd0);
        SRAM_A = 15'h0010; SRAM_DO = 8'h33;
        access(2'b00, 1, 0, 0, 1, 1, 0, wl, nr);
        check("t4_set_wins", 32'(SRAM_DIRTY), 32'd1);

        // ROM read and SRAM write on the same edge: two transactions, write first.
        ROM_A = 23'h000200; SRAM_A = 15'h0001; SRAM_DO = 8'hC7;
        access(2'b00, 1, 1, 0, 2, 0, 0, wl, nr);
        check("t5_two_reqs", 32'(nr), 32'd2);

        // Both ROM write strobes together: one 16-bit write.
        ROM_A = 23'h000321; ROM_DO = 16'h1234;
        access(2'b11, 0, 0, 0, 1, 0, 0, wl, nr);
        check("t6_one_req", 32'(nr), 32'd1);

        // SRAM read returns the low byte.
        SRAM_A = 15'h0042;
        access(2'b00, 0, 0, 1, 3, 0, 0, wl, nr);

        // Address change under a held ROM_RD starts a new read.
        ROM_A = 23'h000300;
        access(2'b00, 0, 1, 0, 0, 0, 1, wl, nr);
        ROM_A = 23'h000301;
        access(2'b00, 0, 1, 0, 1, 0, 0, wl, nr);
        check("t7_addr_change_req", 32'(nr), 32'd1);

        // Reset in BUSY, then a late ack after release.
        auto_ack = 1'b0;
        ROM_A = 23'h000555; ROM_RD = 1'b1;
        repeat (3) cycle();
        check("t8_busy_req",  32'(MEM_REQ), 32'd1);
        check("t8_busy_wait", 32'(WAIT_N), 32'd0);
        RST_N = 1'b0; ROM_RD = 1'b0;
        cycle();
        check("t8_req_dropped", 32'(MEM_REQ), 32'd0);
        check("t8_wait_n",      32'(WAIT_N), 32'd1);
        RST_N = 1'b1;
        cycle();
        MEM_DI = 16'hDEAD; MEM_ACK = 1'b1;
        cycle();
        cycle();
        check("t8_late_ack_rom_di", 32'(ROM_DI), 32'hFFFF);
        check("t8_late_ack_req",    32'(MEM_REQ), 32'd0);
        check("t8_late_ack_wait",   32'(WAIT_N), 32'd1);
        exp_rom_di = 16'hFFFF; exp_sram_di = 8'hFF; exp_dirty = 1'b0; m_vld = 1'b0;
        expq.delete(); have_cur = 1'b0; auto_ack = 1'b1;
        ROM_A = 23'h000100;
        access(2'b00, 0, 1, 0, 0, 0, 0, wl, nr);
        check("t8_cache_cleared", 32'(nr), 32'd1);

        // Randomised batches of simultaneous accesses.
        for (int it = 0; it < 150; it++) begin
            int          m;
            logic [1:0]  rw;
            m  = int'($urandom_range(1, 15));
            rw = m[0] ? 2'($urandom_range(1, 3)) : 2'b00;
            case ($urandom_range(0, 3))
                0:       ROM_A = 23'h000100;
                1:       ROM_A = 23'h000101;
                2:       ROM_A = 23'h7FFFFF;
                default: ROM_A = 23'($urandom);
            endcase
            SRAM_A  = 15'($urandom);
            ROM_DO  = 16'($urandom);
            SRAM_DO = 8'($urandom);
            access(rw, m[1], m[2], m[3], int'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0), 0, wl, nr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
